// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer.
// Holds the reconfig block register map, the 18-bit counter word layout,
// the sequencer state encoding and a counter-width helper.
package pll_cfg_pkg;

    // Reconfig block register addresses.
    localparam logic [5:0] AddrMode   = 6'd0;
    localparam logic [5:0] AddrStatus = 6'd1;
    localparam logic [5:0] AddrStart  = 6'd2;
    localparam logic [5:0] AddrN      = 6'd3;
    localparam logic [5:0] AddrM      = 6'd4;
    localparam logic [5:0] AddrC      = 6'd5;
    localparam logic [5:0] AddrDps    = 6'd6;
    localparam logic [5:0] AddrMfrac  = 6'd7;

    // N/M/C counter word: {odd, bypass, hi[7:0], lo[7:0]}.
    typedef struct packed {
        logic       odd;
        logic       bypass;
        logic [7:0] hi;
        logic [7:0] lo;
    } cnt_word_t;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StGap,
        StWaitLock,
        StDone,
        StErr
    } seq_state_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = (max_val < 2) ? 1 : $clog2(max_val + 1);
        return w;
    endfunction

endpackage

// File: rtl/lock_monitor.sv
// Lock qualification for the reconfig sequencer.
// Synchronises the asynchronous PLL lock, then while run_i is high counts
// consecutive locked cycles and total elapsed cycles.
//   clk_i, rst_ni  : management clock, async active-low reset
//   pll_locked_i   : raw PLL lock (asynchronous)
//   run_i          : high while waiting for lock; low clears both counters
//   lock_ok_o      : LOCK_STABLE consecutive synchronised-lock cycles seen
//   timeout_o      : TIMEOUT_CYC cycles elapsed since run_i rose
module lock_monitor
    import pll_cfg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned LOCK_STABLE = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pll_locked_i,
    input  logic run_i,
    output logic lock_ok_o,
    output logic timeout_o
);

    localparam int unsigned StabW = cnt_width(LOCK_STABLE - 1);
    localparam int unsigned TmoW  = cnt_width(TIMEOUT_CYC - 1);
    localparam logic [StabW-1:0] StabLast = StabW'(LOCK_STABLE - 1);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT_CYC - 1);

    logic             lk_meta_q, lk_s_q;
    logic [StabW-1:0] stab_q, stab_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lk_meta_q <= 1'b0;
            lk_s_q    <= 1'b0;
            stab_q    <= '0;
            tmo_q     <= '0;
        end else begin
            lk_meta_q <= pll_locked_i;
            lk_s_q    <= lk_meta_q;
            stab_q    <= stab_d;
            tmo_q     <= tmo_d;
        end
    end

    // Both counters saturate at their terminal value rather than wrapping.
    always_comb begin
        stab_d = stab_q;
        tmo_d  = tmo_q;
        if (!run_i) begin
            stab_d = '0;
            tmo_d  = '0;
        end else begin
            if (!lk_s_q) begin
                stab_d = '0;
            end else if (stab_q != StabLast) begin
                stab_d = stab_q + StabW'(1);
            end
            if (tmo_q != TmoLast) begin
                tmo_d = tmo_q + TmoW'(1);
            end
        end
    end

    assign lock_ok_o = run_i && lk_s_q && (stab_q == StabLast);
    assign timeout_o = run_i && (tmo_q == TmoLast);

endmodule

// File: rtl/pll_reconfig_seq.sv
// Fractional PLL reconfiguration sequencer.
// Latches a divider set on cfg_req_i, writes MODE, N, M, MFRAC, C0..C(NUM_C-1)
// and START over the reconfig Avalon-MM port, then waits for a stable lock.
// Retries the full sequence up to RETRIES times on timeout, then flags error.
//   clk_i, rst_ni            : management clock, async active-low reset
//   cfg_req_i                : pulse to start with the current cfg_*_i values
//   cfg_n_i, cfg_m_i         : N/M counter words
//   cfg_mfrac_i              : M fractional value
//   cfg_c_i                  : C counter words, C0 in the low 18 bits
//   busy_o, done_o, error_o  : sequence status (done is a one-cycle pulse)
//   domain_rst_n_o           : downstream reset, low while clocks are in flux
//   mgmt_*                   : reconfig management port (master side)
//   pll_locked_i             : raw PLL lock (asynchronous)
module pll_reconfig_seq
    import pll_cfg_pkg::*;
#(
    parameter int unsigned NUM_C       = 4,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned LOCK_STABLE = 256,
    parameter int unsigned RETRIES     = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cfg_req_i,
    input  logic [17:0]           cfg_n_i,
    input  logic [17:0]           cfg_m_i,
    input  logic [31:0]           cfg_mfrac_i,
    input  logic [NUM_C*18-1:0]   cfg_c_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic                  domain_rst_n_o,
    output logic [5:0]            mgmt_address_o,
    output logic                  mgmt_write_o,
    output logic [31:0]           mgmt_writedata_o,
    input  logic                  mgmt_waitrequest_i,
    input  logic                  pll_locked_i
);

    // Write list index: MODE, N, M, MFRAC, C0..C(NUM_C-1), START.
    localparam int unsigned LastItem = NUM_C + 4;
    localparam int unsigned IdxW     = cnt_width(LastItem);
    localparam int unsigned AttW     = cnt_width(RETRIES);

    localparam logic [IdxW-1:0] IdxMode  = IdxW'(0);
    localparam logic [IdxW-1:0] IdxN     = IdxW'(1);
    localparam logic [IdxW-1:0] IdxM     = IdxW'(2);
    localparam logic [IdxW-1:0] IdxMfrac = IdxW'(3);
    localparam logic [IdxW-1:0] IdxStart = IdxW'(LastItem);

    seq_state_e      state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [AttW-1:0] att_q, att_d;

    cnt_word_t   n_q, m_q;
    logic [31:0] mfrac_q;
    cnt_word_t   c_q [NUM_C];

    logic accept;
    logic lock_ok, timeout;

    assign accept = cfg_req_i && ((state_q == StIdle) || (state_q == StErr));

    lock_monitor #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_monitor (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .pll_locked_i (pll_locked_i),
        .run_i        (state_q == StWaitLock),
        .lock_ok_o    (lock_ok),
        .timeout_o    (timeout)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= '0;
            att_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            att_q   <= att_d;
        end
    end

    // Divider set is captured only on an accepted request, so requests that
    // arrive mid-sequence cannot disturb the words being written.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            n_q     <= '0;
            m_q     <= '0;
            mfrac_q <= '0;
            for (int k = 0; k < NUM_C; k++) begin
                c_q[k] <= '0;
            end
        end else if (accept) begin
            n_q     <= cnt_word_t'(cfg_n_i);
            m_q     <= cnt_word_t'(cfg_m_i);
            mfrac_q <= cfg_mfrac_i;
            for (int k = 0; k < NUM_C; k++) begin
                c_q[k] <= cnt_word_t'(cfg_c_i[k*18 +: 18]);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        att_d   = att_q;
        unique case (state_q)
            StIdle, StErr: begin
                if (cfg_req_i) begin
                    state_d = StWr;
                    idx_d   = '0;
                    att_d   = '0;
                end
            end
            StWr: begin
                if (!mgmt_waitrequest_i) begin
                    if (idx_q == IdxStart) begin
                        state_d = StWaitLock;
                    end else begin
                        state_d = StGap;
                        idx_d   = idx_q + IdxW'(1);
                    end
                end
            end
            StGap: begin
                state_d = StWr;
            end
            StWaitLock: begin
                // Lock takes priority over a coincident timeout.
                if (lock_ok) begin
                    state_d = StDone;
                end else if (timeout) begin
                    if (att_q < AttW'(RETRIES)) begin
                        att_d   = att_q + AttW'(1);
                        idx_d   = '0;
                        state_d = StWr;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status and bus outputs decode straight from state so an async reset
    // drops them immediately.
    always_comb begin
        busy_o           = (state_q == StWr) || (state_q == StGap) || (state_q == StWaitLock);
        done_o           = (state_q == StDone);
        error_o          = (state_q == StErr);
        domain_rst_n_o   = (state_q == StIdle) || (state_q == StDone);
        mgmt_write_o     = (state_q == StWr);
        mgmt_address_o   = '0;
        mgmt_writedata_o = '0;
        if (state_q == StWr) begin
            if (idx_q == IdxMode) begin
                mgmt_address_o   = AddrMode;
                mgmt_writedata_o = 32'd0;
            end else if (idx_q == IdxN) begin
                mgmt_address_o   = AddrN;
                mgmt_writedata_o = {14'd0, n_q};
            end else if (idx_q == IdxM) begin
                mgmt_address_o   = AddrM;
                mgmt_writedata_o = {14'd0, m_q};
            end else if (idx_q == IdxMfrac) begin
                mgmt_address_o   = AddrMfrac;
                mgmt_writedata_o = mfrac_q;
            end else if (idx_q == IdxStart) begin
                mgmt_address_o   = AddrStart;
                mgmt_writedata_o = 32'd1;
            end else begin
                // C writes carry the counter index in [22:18].
                for (int k = 0; k < NUM_C; k++) begin
                    if (idx_q == IdxW'(k + 4)) begin
                        mgmt_address_o   = AddrC;
                        mgmt_writedata_o = {9'd0, 5'(k), c_q[k]};
                    end
                end
            end
        end
    end

endmodule
